// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush and EX operand forwarding.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
   parameter int unsigned FLUSH_CYC = 1,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ID_VALID,
   input  logic [4:0]       RS_ADD,
   input  logic [4:0]       RT_ADD,
   input  logic [4:0]       RD_ADD,
   input  logic             WB_EN,
   input  logic             IS_LD,
   input  logic             IS_IMM,
   input  logic             MEM_EN,
   input  logic             BR_TAKEN,
   output logic             STALL,
   output logic             FLUSH,
   output logic [1:0]       FWD_A,
   output logic [1:0]       FWD_B,
   output logic [CNT_W-1:0] STALL_CNT,
   output logic [CNT_W-1:0] FLUSH_CNT
);

   localparam int unsigned REG_W = 5;
   localparam int unsigned FC_W  = 3;
   localparam int unsigned SEL_W = 2;

   typedef struct packed {
      logic             v;
      logic [REG_W-1:0] rd;
   } sb_t;

   typedef enum logic {IDLE, FLUSHING} fstate_t;

   sb_t             sb_e, sb_m, sb_w, sb_e_n;
   logic            e_ld, e_ld_n;
   fstate_t         state, state_n;
   logic [FC_W-1:0] fc, fc_n;
   logic            use_a, use_b, advance;
   logic            stall_int, flush_int;
   logic [SEL_W-1:0] sel_a, sel_b;

   function automatic logic hit(input sb_t s, input logic [REG_W-1:0] op);
      return s.v && (s.rd == op) && (op != '0);
   endfunction

   // Nearest in-flight producer wins.
   function automatic logic [SEL_W-1:0] fwd_sel(input logic en, input logic [REG_W-1:0] op,
                                                input sb_t e, input sb_t m, input sb_t w);
      if (!en)              return SEL_W'(0);
      else if (hit(e, op))  return SEL_W'(1);
      else if (hit(m, op))  return SEL_W'(2);
      else if (hit(w, op))  return SEL_W'(3);
      else                  return SEL_W'(0);
   endfunction

   assign use_a     = ID_VALID;
   assign use_b     = ID_VALID && (!IS_IMM || MEM_EN);
   assign flush_int = !RST && (BR_TAKEN || (fc != '0));
   assign stall_int = !RST && !flush_int && sb_e.v && e_ld &&
                      ((use_a && hit(sb_e, RS_ADD)) || (use_b && hit(sb_e, RT_ADD)));
   assign advance   = !(stall_int || flush_int);
   assign STALL     = stall_int;
   assign FLUSH     = flush_int;
   assign sel_a     = fwd_sel(use_a, RS_ADD, sb_e, sb_m, sb_w);
   assign sel_b     = fwd_sel(use_b, RT_ADD, sb_e, sb_m, sb_w);

   // Next scoreboard entry for E: the advancing decode instruction or a bubble.
   always_comb begin
      sb_e_n = '0;
      e_ld_n = 1'b0;
      if (advance) begin
         sb_e_n.v  = ID_VALID && WB_EN && (RD_ADD != '0);
         sb_e_n.rd = RD_ADD;
         e_ld_n    = IS_LD;
      end
   end

   // Flush FSM next state; a taken branch always reloads the counter.
   always_comb begin
      state_n = state;
      fc_n    = fc;
      if (BR_TAKEN) begin
         fc_n    = FC_W'(FLUSH_CYC - 1);
         state_n = (fc_n != '0) ? FLUSHING : IDLE;
      end else if (state == FLUSHING) begin
         fc_n    = fc - FC_W'(1);
         state_n = (fc_n == '0) ? IDLE : FLUSHING;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
         fc    <= '0;
      end else begin
         state <= state_n;
         fc    <= fc_n;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sb_e  <= '0;
         sb_m  <= '0;
         sb_w  <= '0;
         e_ld  <= 1'b0;
         FWD_A <= '0;
         FWD_B <= '0;
      end else begin
         sb_w  <= sb_m;
         sb_m  <= sb_e;
         sb_e  <= sb_e_n;
         e_ld  <= e_ld_n;
         FWD_A <= advance ? sel_a : SEL_W'(0);
         FWD_B <= advance ? sel_b : SEL_W'(0);
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   // Saturating event counters.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_int && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
         if (flush_int && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

   assign STALL_CNT = stall_cnt;
   assign FLUSH_CNT = flush_cnt;
`else
   assign STALL_CNT = '0;
   assign FLUSH_CNT = '0;
`endif

endmodule
